// File: rtl/w_run_gen.sv
// w_run_gen: drives the serial w line with repeated runs of 1s separated by gaps of 0s,
// and counts trigger rising edges from the detector, recording when the first one fired.
// Ports: clock_i/reset_i (async, active-low); start_i with run_len_i/gap_len_i/reps_i launches
// a pattern; trigger_i is the detector return. ready_o/busy_o/done_o show status, w_o is the
// stimulus, and trig_count_o/first_trig_o hold the trigger statistics. All outputs are registered.
module w_run_gen #(
    parameter int LEN_W  = 4,
    parameter int REP_W  = 4,
    parameter int CNT_W  = 4,
    parameter int TIME_W = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,      // active-low, asynchronous
    input  logic              start_i,
    input  logic [LEN_W-1:0]  run_len_i,
    input  logic [LEN_W-1:0]  gap_len_i,
    input  logic [REP_W-1:0]  reps_i,
    input  logic              trigger_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              w_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  trig_count_o,
    output logic [TIME_W-1:0] first_trig_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    run_len_q, run_len_d;
    logic [LEN_W-1:0]    gap_len_q, gap_len_d;
    logic [REP_W-1:0]    reps_q, reps_d;
    logic [LEN_W-1:0]    len_cnt_q, len_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [TIME_W-1:0]   elapsed_q, elapsed_d;
    logic [CNT_W-1:0]    trig_cnt_q, trig_cnt_d;
    logic [TIME_W-1:0]   first_q, first_d;
    logic                seen_q, seen_d;
    logic                trigger_q;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                w_q, w_d;

    logic rise;
    logic run_last;
    logic gap_last;
    logic rep_last;

    assign rise = trigger_i & ~trigger_q;

    // Terminal counts compare against latched length minus one. RUN is only entered with
    // run_len_q != 0 and GAP only with gap_len_q != 0, so these never underflow in use.
    assign run_last = (len_cnt_q == run_len_q - LEN_W'(1));
    assign gap_last = (len_cnt_q == gap_len_q - LEN_W'(1));
    assign rep_last = (rep_cnt_q == reps_q - REP_W'(1));

    always_comb begin
        state_d    = state_q;
        run_len_d  = run_len_q;
        gap_len_d  = gap_len_q;
        reps_d     = reps_q;
        len_cnt_d  = len_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        elapsed_d  = elapsed_q;
        trig_cnt_d = trig_cnt_q;
        first_d    = first_q;
        seen_d     = seen_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    run_len_d  = run_len_i;
                    gap_len_d  = gap_len_i;
                    reps_d     = reps_i;
                    len_cnt_d  = '0;
                    rep_cnt_d  = '0;
                    elapsed_d  = '0;
                    trig_cnt_d = '0;
                    first_d    = '1;
                    seen_d     = 1'b0;
                    // A zero-length run or zero reps emits nothing, not even a gap.
                    if (run_len_i == '0 || reps_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                len_cnt_d = len_cnt_q + LEN_W'(1);
                if (run_last) begin
                    len_cnt_d = '0;
                    if (gap_len_q != '0) begin
                        state_d = S_GAP;
                    end else if (rep_last) begin
                        state_d = S_DONE;
                    end else begin
                        // No gap: the next run follows immediately and merges on w.
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            S_GAP: begin
                len_cnt_d = len_cnt_q + LEN_W'(1);
                if (gap_last) begin
                    len_cnt_d = '0;
                    if (rep_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Trigger monitor: only edges seen while the pattern is on the line count. A trigger
        // already high at acceptance is absorbed by trigger_q and produces no edge.
        if (state_q == S_RUN || state_q == S_GAP) begin
            if (elapsed_q != '1) begin
                elapsed_d = elapsed_q + TIME_W'(1);
            end
            if (rise) begin
                if (trig_cnt_q != '1) begin
                    trig_cnt_d = trig_cnt_q + CNT_W'(1);
                end
                if (!seen_q) begin
                    first_d = elapsed_q;
                    seen_d  = 1'b1;
                end
            end
        end
    end

    // Status outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
        w_d     = (state_d == S_RUN);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            run_len_q  <= '0;
            gap_len_q  <= '0;
            reps_q     <= '0;
            len_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            elapsed_q  <= '0;
            trig_cnt_q <= '0;
            first_q    <= '1;
            seen_q     <= 1'b0;
            trigger_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_len_q  <= run_len_d;
            gap_len_q  <= gap_len_d;
            reps_q     <= reps_d;
            len_cnt_q  <= len_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            elapsed_q  <= elapsed_d;
            trig_cnt_q <= trig_cnt_d;
            first_q    <= first_d;
            seen_q     <= seen_d;
            trigger_q  <= trigger_i;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            w_q        <= w_d;
        end
    end

    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign w_o          = w_q;
    assign trig_count_o = trig_cnt_q;
    assign first_trig_o = first_q;

endmodule

// File: tb/tb_w_run_gen.sv
// Bench for w_run_gen: a queue-based model of the expected w/busy/done stream plus trigger
// statistics, checked every cycle, with directed scenarios and a randomized phase.
module tb_w_run_gen;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] run_len = '0;
    logic [3:0] gap_len = '0;
    logic [3:0] reps = '0;
    logic       trigger = 1'b0;
    logic       ready, busy, w, done;
    logic [3:0] trig_count;
    logic [7:0] first_trig;

    int n_cmp = 0;
    int n_bad = 0;

    w_run_gen dut (
        .clock_i      (clock),
        .reset_i      (rst_n),
        .start_i      (start),
        .run_len_i    (run_len),
        .gap_len_i    (gap_len),
        .reps_i       (reps),
        .trigger_i    (trigger),
        .ready_o      (ready),
        .busy_o       (busy),
        .w_o          (w),
        .done_o       (done),
        .trig_count_o (trig_count),
        .first_trig_o (first_trig)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each queued entry is one future cycle: {w, busy, done}. Empty queue means idle/ready.
    logic [2:0] m_q[$];
    int         m_cnt  = 0;
    int         m_first = 255;
    bit         m_seen = 0;
    int         m_idx  = 0;
    bit         m_prev = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0; m_first = 255; m_seen = 0; m_idx = 0; m_prev = 0;
        end else begin
            logic [2:0] cur;
            cur = (m_q.size() > 0) ? m_q[0] : 3'b000;
            if (cur[1]) begin
                if (trigger && !m_prev) begin
                    if (m_cnt < 15) m_cnt++;
                    if (!m_seen) begin m_seen = 1; m_first = m_idx; end
                end
                if (m_idx < 255) m_idx++;
            end
            m_prev = trigger;
            if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end else if (start) begin
                m_cnt = 0; m_first = 255; m_seen = 0; m_idx = 0;
                if (run_len != 0 && reps != 0) begin
                    for (int r = 0; r < int'(reps); r++) begin
                        for (int i = 0; i < int'(run_len); i++) m_q.push_back(3'b110);
                        for (int i = 0; i < int'(gap_len); i++) m_q.push_back(3'b010);
                    end
                end
                m_q.push_back(3'b001);
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        logic [2:0] cur;
        cur = (m_q.size() > 0) ? m_q[0] : 3'b000;
        chk("w",          int'(w),          int'(cur[2]));
        chk("busy",       int'(busy),       int'(cur[1]));
        chk("done",       int'(done),       int'(cur[0]));
        chk("ready",      int'(ready),      (m_q.size() == 0) ? 1 : 0);
        chk("trig_count", int'(trig_count), m_cnt);
        chk("first_trig", int'(first_trig), m_first);
    end

    // ---------------- stimulus ----------------
    int          busy_n;
    int          done_t;
    logic [63:0] wbits;

    // Launch one pattern and follow it to its done pulse. tmode: 0 none, 1 high from
    // elapsed index 3 onward, 2 toggle every cycle, 3 random.
    task automatic run_pat(input int rl, input int gl, input int rp, input int tmode,
                           input bit hold_start);
        int t;
        bit seen_done;
        run_len = 4'(rl); gap_len = 4'(gl); reps = 4'(rp);
        start = 1'b1;
        @(posedge clock); #1;
        if (!hold_start) start = 1'b0;
        t = 1; busy_n = 0; done_t = -1; wbits = '0; seen_done = 0;
        while (!seen_done && t < 600) begin
            case (tmode)
                1: trigger = (t >= 4);
                2: trigger = t[0];
                3: trigger = 1'($urandom_range(0, 1));
                default: trigger = 1'b0;
            endcase
            @(negedge clock);
            if (busy) busy_n++;
            wbits = {wbits[62:0], w};
            if (done) begin seen_done = 1; done_t = t; end
            @(posedge clock); #1;
            t++;
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        start = 1'b0;
        trigger = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", int'(ready), 1);
        chk("rst_first", int'(first_trig), 255);
        rst_n = 1'b1;
        @(posedge clock); #1;

        // 1: async reset in the middle of a run
        run_len = 4'd7; gap_len = 4'd0; reps = 4'd1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("t1_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_w",     int'(w), 0);
        chk("t1_busy",  int'(busy), 0);
        chk("t1_done",  int'(done), 0);
        chk("t1_ready", int'(ready), 1);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("t1_cnt",   int'(trig_count), 0);
        chk("t1_first", int'(first_trig), 255);
        @(posedge clock); #1;

        // 2: single run with gap
        run_pat(5, 2, 1, 0, 0);
        chk("t2_done_t", done_t, 8);
        chk("t2_wbits",  int'(wbits[7:0]), int'(8'b1111_1000));
        chk("t2_busy_n", busy_n, 7);
        @(negedge clock);
        chk("t2_ready",  int'(ready), 1);
        chk("t2_first",  int'(first_trig), 255);
        @(posedge clock); #1;

        // 3: three reps, start held high throughout
        run_pat(3, 1, 3, 0, 1);
        chk("t3_busy_n", busy_n, 12);
        chk("t3_wbits",  int'(wbits[12:0]), int'(13'b1110_1110_1110_0));
        @(negedge clock);
        chk("t3_idle_busy", int'(busy), 0);

        // 4: degenerate launches
        @(posedge clock); #1;
        run_pat(0, 3, 2, 0, 0);
        chk("t4a_done_t", done_t, 1);
        chk("t4a_busy_n", busy_n, 0);
        run_pat(4, 2, 0, 0, 0);
        chk("t4b_done_t", done_t, 1);
        chk("t4b_wbits",  int'(wbits[0]), 0);

        // 5: trigger raised at elapsed index 3 and held
        run_pat(7, 0, 1, 1, 0);
        chk("t5_cnt",   int'(trig_count), 1);
        chk("t5_first", int'(first_trig), 3);

        // 6: merged runs, then saturation
        run_pat(2, 0, 2, 0, 0);
        chk("t6a_wbits", int'(wbits[4:0]), int'(5'b11110));
        chk("t6a_done_t", done_t, 5);
        run_pat(15, 15, 2, 2, 0);
        chk("t6b_cnt",   int'(trig_count), 15);
        chk("t6b_first", int'(first_trig), 0);

        // randomized patterns, trigger random
        for (int k = 0; k < 30; k++) begin
            run_pat(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), 3, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
            end
        end

        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
